fft_peak_det: RTL and testbench
===============================

Name: fft_peak_det

Overview:
- Post-processing stage directly downstream of the 64-point FFT top.
- Consumes the FFT's serial complex output stream (vld/re/im, one bin per valid cycle, bins in order 0..63).
- Per 64-bin frame, computes per-bin power |X|^2, finds the peak bin and accumulates total frame power.
- Reports the peak index, peak power and total power with a one-cycle result strobe.

Parameters:
- FFT_DAT_WD, 10, signed width of the re/im input samples; must match the FFT data width.
- SIZE_FFT, 64, bins per frame; fixed at 64, so the index is 6 bits.
- SKIP_DC, 0, when 1, bin 0 is excluded from the peak search but still included in total power.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr_i  input  1  synchronous frame abort; discards the partial frame.
- vld_i  input  1  input sample valid.
- fft_dat_re_i  input  FFT_DAT_WD  bin real part, two's complement.
- fft_dat_im_i  input  FFT_DAT_WD  bin imaginary part, two's complement.
- vld_o  output  1  one-cycle result strobe.
- pk_idx_o  output  6  peak bin index.
- pk_pwr_o  output  2*FFT_DAT_WD  peak bin power, unsigned.
- tot_pwr_o  output  2*FFT_DAT_WD+6  sum of all 64 bin powers, unsigned.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - Asserting rst_n=0 immediately clears the bin counter, all pipeline valid bits, accumulators, vld_o, pk_idx_o, pk_pwr_o and tot_pwr_o to 0.
  - Reset may occur mid-frame; the partial frame is lost.
- Bin counter:
  - 6-bit, increments on each accepted sample (vld_i=1 and clr_i=0).
  - Wraps 63->0.
  - Its value tags each sample as the bin index.
- Pipeline: 3 registered stages, advancing every cycle with a valid bit per stage.
  - S1: registers re*re and im*im (signed multiply, results non-negative) plus index and valid.
  - S2: registers pwr = sq_re + sq_im, 2*FFT_DAT_WD bits unsigned. Max value 2^(2*FFT_DAT_WD-1), so no overflow.
  - S3: updates the running max and running sum. When the tag is 63, updates the outputs.
- Latency: if the bin-63 sample is sampled at edge E0, vld_o is high for exactly the cycle following edge E0+3.
- Gaps: vld_i may deassert anywhere, including mid-frame; gaps only delay results.
  - Back-to-back frames need no idle cycle; consecutive vld_o strobes are at least 64 cycles apart.
- Running max:
  - Carries an "empty" flag, set at frame start.
  - The first eligible bin loads unconditionally. This is bin 0, or bin 1 if SKIP_DC=1.
  - Later bins replace the max only if strictly greater, so ties resolve to the lowest index.
- Running sum:
  - Bin 0 loads pwr directly; other bins add pwr.
  - Width 2*FFT_DAT_WD+6; cannot overflow.
- Output update, at the S3 edge for tag 63:
  - pk_idx_o, pk_pwr_o and tot_pwr_o load the final frame values in the same edge, including bin 63's contribution.
  - vld_o=1 for that one cycle only.
  - Outputs hold their values until the next frame completes.
- clr_i=1:
  - Clears the bin counter, all pipeline valid bits, the running max/sum and the empty flag.
  - Does not alter pk_* / tot_* outputs.
  - A pending vld_o for a frame whose tag-63 sample is already in S1/S2 is suppressed.
  - If clr_i and vld_i are high in the same cycle, clr_i wins and the sample is dropped.
- No backpressure: the block always accepts input.

Test Plan:
- Single tone (FFT_DAT_WD=10): bin 5 re=100 im=0, all others 0 -> one vld_o pulse exactly 3 cycles after the bin-63 sample; pk_idx_o=5, pk_pwr_o=10000, tot_pwr_o=10000.
- Tie: bins 10 and 40 re=-512 im=0, others 0 -> pk_idx_o=10, pk_pwr_o=262144, tot_pwr_o=524288.
- Full scale: all 64 bins re=-512 im=-512 -> pk_idx_o=0, pk_pwr_o=524288, tot_pwr_o=33554432; no overflow.
- Gapped and back-to-back: vld_i toggles every other cycle with the single-tone frame -> identical results. Then two frames with no gap (tone at bin 5, then bin 63 re=-3 im=4) -> second strobe 64 cycles after the first, pk_idx_o=63, pk_pwr_o=25.
- Abort and reset: 30 samples, then clr_i for 1 cycle, then the single-tone frame -> exactly one vld_o, results as in scenario 1. Assert rst_n=0 mid-frame -> all outputs 0 immediately.
- SKIP_DC=1: bin 0 re=500, bin 3 re=20, others 0 -> pk_idx_o=3, pk_pwr_o=400, tot_pwr_o=250400.

Source files
------------

// File: rtl/fft_peak_det_if.sv
// Stream and result bundle between the FFT output and the peak detector.
// The slave modport is the detector side; the master modport is the upstream/consumer side.
interface fft_peak_det_if #(
  parameter int FFT_DAT_WD = 10
);
  logic                          clr_i;
  logic                          vld_i;
  logic signed [FFT_DAT_WD-1:0]  fft_dat_re_i;
  logic signed [FFT_DAT_WD-1:0]  fft_dat_im_i;
  logic                          vld_o;
  logic [5:0]                    pk_idx_o;
  logic [2*FFT_DAT_WD-1:0]       pk_pwr_o;
  logic [2*FFT_DAT_WD+5:0]       tot_pwr_o;

  modport master (
    output clr_i, vld_i, fft_dat_re_i, fft_dat_im_i,
    input  vld_o, pk_idx_o, pk_pwr_o, tot_pwr_o
  );

  modport slave (
    input  clr_i, vld_i, fft_dat_re_i, fft_dat_im_i,
    output vld_o, pk_idx_o, pk_pwr_o, tot_pwr_o
  );
endinterface

// File: rtl/fft_peak_det.sv
// Per-frame peak bin and total power over the serial 64-bin FFT output stream.
// Input register, square, sum and accumulate stages; the result strobe follows the bin-63 capture edge by three edges.
module fft_peak_det #(
  parameter int FFT_DAT_WD = 10,
  parameter int SIZE_FFT   = 64,
  parameter int SKIP_DC    = 0
) (
  input logic           clk,
  input logic           rst_n,
  fft_peak_det_if.slave bus
);
  localparam int         PW       = 2 * FFT_DAT_WD;
  localparam int         TW       = PW + 6;
  localparam logic [5:0] LAST_BIN = 6'(SIZE_FFT - 1);

  logic                         w_acc;
  logic [5:0]                   r_cnt;

  logic                         r_s0_vld;
  logic [5:0]                   r_s0_idx;
  logic signed [FFT_DAT_WD-1:0] r_s0_re;
  logic signed [FFT_DAT_WD-1:0] r_s0_im;

  logic                         r_s1_vld;
  logic [5:0]                   r_s1_idx;
  logic [PW-1:0]                r_s1_sq_re;
  logic [PW-1:0]                r_s1_sq_im;

  logic                         r_s2_vld;
  logic [5:0]                   r_s2_idx;
  logic [PW-1:0]                r_s2_pwr;

  logic                         r_empty;
  logic [PW-1:0]                r_max_pwr;
  logic [5:0]                   r_max_idx;
  logic [TW-1:0]                r_sum;

  logic                         r_vld_o;
  logic [5:0]                   r_pk_idx;
  logic [PW-1:0]                r_pk_pwr;
  logic [TW-1:0]                r_tot_pwr;

  logic signed [PW-1:0]         w_re_ext;
  logic signed [PW-1:0]         w_im_ext;
  logic signed [PW-1:0]         w_sq_re;
  logic signed [PW-1:0]         w_sq_im;

  logic                         w_elig;
  logic                         w_empty_in;
  logic                         w_take;
  logic [PW-1:0]                w_max_pwr_nxt;
  logic [5:0]                   w_max_idx_nxt;
  logic [TW-1:0]                w_sum_nxt;

  assign w_acc = bus.vld_i & ~bus.clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_s0_vld <= 1'b0;
      r_s0_idx <= '0;
      r_s0_re  <= '0;
      r_s0_im  <= '0;
    end else begin
      r_s0_vld <= w_acc;
      if (bus.clr_i) begin
        r_cnt <= '0;
      end else if (bus.vld_i) begin
        r_cnt    <= r_cnt + 6'd1;
        r_s0_idx <= r_cnt;
        r_s0_re  <= bus.fft_dat_re_i;
        r_s0_im  <= bus.fft_dat_im_i;
      end
    end
  end

  // Sign-extend before squaring so the product is computed at full power width.
  assign w_re_ext = PW'(r_s0_re);
  assign w_im_ext = PW'(r_s0_im);
  assign w_sq_re  = w_re_ext * w_re_ext;
  assign w_sq_im  = w_im_ext * w_im_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_sq_re <= '0;
      r_s1_sq_im <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_pwr   <= '0;
    end else begin
      r_s1_vld <= r_s0_vld & ~bus.clr_i;
      r_s2_vld <= r_s1_vld & ~bus.clr_i;
      if (r_s0_vld) begin
        r_s1_idx   <= r_s0_idx;
        r_s1_sq_re <= $unsigned(w_sq_re);
        r_s1_sq_im <= $unsigned(w_sq_im);
      end
      if (r_s1_vld) begin
        r_s2_idx <= r_s1_idx;
        r_s2_pwr <= r_s1_sq_re + r_s1_sq_im;
      end
    end
  end

  // Bin 0 always opens a new frame; with DC skipped it is summed but never ranked.
  assign w_elig        = (SKIP_DC == 0) || (r_s2_idx != 6'd0);
  assign w_empty_in    = (r_s2_idx == 6'd0) || r_empty;
  assign w_take        = w_elig && (w_empty_in || (r_s2_pwr > r_max_pwr));
  assign w_max_pwr_nxt = w_take ? r_s2_pwr : r_max_pwr;
  assign w_max_idx_nxt = w_take ? r_s2_idx : r_max_idx;
  assign w_sum_nxt     = (r_s2_idx == 6'd0) ? TW'(r_s2_pwr) : r_sum + TW'(r_s2_pwr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_empty   <= 1'b0;
      r_max_pwr <= '0;
      r_max_idx <= '0;
      r_sum     <= '0;
      r_vld_o   <= 1'b0;
      r_pk_idx  <= '0;
      r_pk_pwr  <= '0;
      r_tot_pwr <= '0;
    end else if (bus.clr_i) begin
      r_empty   <= 1'b0;
      r_max_pwr <= '0;
      r_max_idx <= '0;
      r_sum     <= '0;
      r_vld_o   <= 1'b0;
    end else begin
      r_vld_o <= 1'b0;
      if (r_s2_vld) begin
        r_empty   <= w_empty_in & ~w_take;
        r_max_pwr <= w_max_pwr_nxt;
        r_max_idx <= w_max_idx_nxt;
        r_sum     <= w_sum_nxt;
        if (r_s2_idx == LAST_BIN) begin
          r_vld_o   <= 1'b1;
          r_pk_idx  <= w_max_idx_nxt;
          r_pk_pwr  <= w_max_pwr_nxt;
          r_tot_pwr <= w_sum_nxt;
          r_empty   <= 1'b1;
        end
      end
    end
  end

  assign bus.vld_o     = r_vld_o;
  assign bus.pk_idx_o  = r_pk_idx;
  assign bus.pk_pwr_o  = r_pk_pwr;
  assign bus.tot_pwr_o = r_tot_pwr;
endmodule

// File: tb/tb_fft_peak_det.sv
// Bench for fft_peak_det: two instances (DC ranked / DC skipped) share one stimulus stream,
// checked every cycle against a frame-level model plus literal results per scenario.
module tb_fft_peak_det;
  localparam int W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fft_peak_det_if #(.FFT_DAT_WD(W)) bus0 ();
  fft_peak_det_if #(.FFT_DAT_WD(W)) bus1 ();

  fft_peak_det #(.FFT_DAT_WD(W), .SIZE_FFT(64), .SKIP_DC(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fft_peak_det #(.FFT_DAT_WD(W), .SIZE_FFT(64), .SKIP_DC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus1.clr_i        = bus0.clr_i;
  assign bus1.vld_i        = bus0.vld_i;
  assign bus1.fft_dat_re_i = bus0.fft_dat_re_i;
  assign bus1.fft_dat_im_i = bus0.fft_dat_im_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct {
    int     due;
    int     idx0;
    longint pk0;
    int     idx1;
    longint pk1;
    longint tot;
  } res_t;

  res_t   pend[$];
  longint pw[64];
  int     nacc       = 0;
  int     ecnt       = 0;
  int     last63_edge = 0;
  longint rr, ii;
  res_t   nr;

  always @(posedge clk) begin
    ecnt++;
    if (!rst_n) begin
      nacc = 0;
      pend.delete();
    end else if (bus0.clr_i) begin
      nacc = 0;
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due >= ecnt) pend.delete(i);
    end else if (bus0.vld_i) begin
      rr = longint'(bus0.fft_dat_re_i);
      ii = longint'(bus0.fft_dat_im_i);
      pw[nacc] = rr * rr + ii * ii;
      nacc++;
      if (nacc == 64) begin
        nr.due  = ecnt + 3;
        nr.idx0 = 0;  nr.pk0 = pw[0];
        nr.idx1 = 1;  nr.pk1 = pw[1];
        nr.tot  = 0;
        for (int i = 0; i < 64; i++) begin
          nr.tot += pw[i];
          if (pw[i] > nr.pk0) begin nr.pk0 = pw[i]; nr.idx0 = i; end
          if (i >= 2 && pw[i] > nr.pk1) begin nr.pk1 = pw[i]; nr.idx1 = i; end
        end
        pend.push_back(nr);
        last63_edge = ecnt;
        nacc = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  longint ev, ex_idx0, ex_pk0, ex_idx1, ex_pk1, ex_tot;
  int     strobes     = 0;
  int     last_strobe = 0;
  int     prev_strobe = 0;

  initial begin
    ev = 0; ex_idx0 = 0; ex_pk0 = 0; ex_idx1 = 0; ex_pk1 = 0; ex_tot = 0;
  end

  always @(posedge clk) begin
    #1;
    ev = 0;
    if (!rst_n) begin
      ex_idx0 = 0; ex_pk0 = 0; ex_idx1 = 0; ex_pk1 = 0; ex_tot = 0;
    end else if (pend.size() > 0 && pend[0].due == ecnt) begin
      ev      = 1;
      ex_idx0 = pend[0].idx0;  ex_pk0 = pend[0].pk0;
      ex_idx1 = pend[0].idx1;  ex_pk1 = pend[0].pk1;
      ex_tot  = pend[0].tot;
      pend.delete(0);
    end
    chk("vld0", longint'(bus0.vld_o),     ev);
    chk("idx0", longint'(bus0.pk_idx_o),  ex_idx0);
    chk("pk0",  longint'(bus0.pk_pwr_o),  ex_pk0);
    chk("tot0", longint'(bus0.tot_pwr_o), ex_tot);
    chk("vld1", longint'(bus1.vld_o),     ev);
    chk("idx1", longint'(bus1.pk_idx_o),  ex_idx1);
    chk("pk1",  longint'(bus1.pk_pwr_o),  ex_pk1);
    chk("tot1", longint'(bus1.tot_pwr_o), ex_tot);
    if (bus0.vld_o === 1'b1) begin
      strobes++;
      prev_strobe = last_strobe;
      last_strobe = ecnt;
    end
  end

  // ---------------- stimulus ----------------
  int f_re[64];
  int f_im[64];

  task automatic put(input logic v, input logic c, input int re, input int im);
    @(negedge clk);
    bus0.vld_i        = v;
    bus0.clr_i        = c;
    bus0.fft_dat_re_i = W'(re);
    bus0.fft_dat_im_i = W'(im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 1'b0, 0, 0);
  endtask

  task automatic zero_frame();
    for (int i = 0; i < 64; i++) begin f_re[i] = 0; f_im[i] = 0; end
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < 64; i++) begin
      put(1'b1, 1'b0, f_re[i], f_im[i]);
      if (gap != 0) put(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic check_res(input string tag, input int i0, input longint p0,
                           input int i1, input longint p1, input longint t);
    chk({tag, "_dut_idx0"}, longint'(bus0.pk_idx_o),  i0);
    chk({tag, "_dut_pk0"},  longint'(bus0.pk_pwr_o),  p0);
    chk({tag, "_dut_tot0"}, longint'(bus0.tot_pwr_o), t);
    chk({tag, "_dut_idx1"}, longint'(bus1.pk_idx_o),  i1);
    chk({tag, "_dut_pk1"},  longint'(bus1.pk_pwr_o),  p1);
    chk({tag, "_dut_tot1"}, longint'(bus1.tot_pwr_o), t);
    chk({tag, "_mdl_idx0"}, ex_idx0, i0);
    chk({tag, "_mdl_pk0"},  ex_pk0,  p0);
    chk({tag, "_mdl_idx1"}, ex_idx1, i1);
    chk({tag, "_mdl_pk1"},  ex_pk1,  p1);
    chk({tag, "_mdl_tot"},  ex_tot,  t);
  endtask

  int s0;

  initial begin
    bus0.vld_i = 1'b0; bus0.clr_i = 1'b0;
    bus0.fft_dat_re_i = '0; bus0.fft_dat_im_i = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", longint'(bus0.vld_o), 0);
    check_res("rst", 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // single tone
    zero_frame(); f_re[5] = 100;
    s0 = strobes;
    send_frame(0); idle(6);
    chk("tone_strobes", strobes - s0, 1);
    chk("tone_latency", last_strobe - last63_edge, 3);
    check_res("tone", 5, 10000, 5, 10000, 10000);

    // tie resolves to lowest index
    zero_frame(); f_re[10] = -512; f_re[40] = -512;
    send_frame(0); idle(6);
    check_res("tie", 10, 262144, 10, 262144, 524288);

    // full scale
    for (int i = 0; i < 64; i++) begin f_re[i] = -512; f_im[i] = -512; end
    send_frame(0); idle(6);
    check_res("full", 0, 524288, 1, 524288, 33554432);

    // gapped tone
    zero_frame(); f_re[5] = 100;
    s0 = strobes;
    send_frame(1); idle(6);
    chk("gap_strobes", strobes - s0, 1);
    chk("gap_latency", last_strobe - last63_edge, 3);
    check_res("gap", 5, 10000, 5, 10000, 10000);

    // back-to-back frames
    s0 = strobes;
    send_frame(0);
    zero_frame(); f_re[63] = -3; f_im[63] = 4;
    send_frame(0); idle(6);
    chk("b2b_strobes", strobes - s0, 2);
    chk("b2b_spacing", last_strobe - prev_strobe, 64);
    check_res("b2b", 63, 25, 63, 25, 25);

    // abort after 30 samples; clr arrives together with a valid sample
    for (int i = 0; i < 30; i++) put(1'b1, 1'b0, i * 7, -i);
    put(1'b1, 1'b1, 200, 200);
    zero_frame(); f_re[5] = 100;
    s0 = strobes;
    send_frame(0); idle(6);
    chk("abort_strobes", strobes - s0, 1);
    check_res("abort", 5, 10000, 5, 10000, 10000);

    // clr right after bin 63 suppresses the pending result
    zero_frame(); f_re[7] = 9;
    s0 = strobes;
    send_frame(0);
    put(1'b0, 1'b1, 0, 0);
    idle(6);
    chk("supp_strobes", strobes - s0, 0);
    check_res("supp", 5, 10000, 5, 10000, 10000);

    // DC bin large: ranked by dut0, skipped by dut1
    zero_frame(); f_re[0] = 500; f_re[3] = 20;
    send_frame(0); idle(6);
    check_res("skipdc", 0, 250000, 3, 400, 250400);

    // asynchronous reset mid-frame
    for (int i = 0; i < 20; i++) put(1'b1, 1'b0, 50, 50);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", longint'(bus0.vld_o), 0);
    chk("mrst_idx0", longint'(bus0.pk_idx_o), 0);
    chk("mrst_pk0", longint'(bus0.pk_pwr_o), 0);
    chk("mrst_tot0", longint'(bus0.tot_pwr_o), 0);
    chk("mrst_pk1", longint'(bus1.pk_pwr_o), 0);
    chk("mrst_tot1", longint'(bus1.tot_pwr_o), 0);
    bus0.vld_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // recovery after reset
    zero_frame(); f_re[5] = 100;
    s0 = strobes;
    send_frame(0); idle(6);
    chk("rec_strobes", strobes - s0, 1);
    check_res("rec", 5, 10000, 5, 10000, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
